// File: rtl/booth_pp_accumulator_if.sv
// Operand/result handshake bundle for booth_pp_accumulator.
// master drives operands and out_ready; slave is the multiply-accumulate engine.
interface booth_pp_accumulator_if #(
   parameter int N_BITS   = 16,
   parameter int ACC_BITS = 40
);
   logic                         in_valid;
   logic                         in_ready;
   logic signed [N_BITS-1:0]     multiplicand;
   logic signed [N_BITS-1:0]     multiplier;
   logic                         acc_clear;
   logic                         out_valid;
   logic                         out_ready;
   logic signed [2*N_BITS-1:0]   product;
   logic signed [ACC_BITS-1:0]   acc_out;
   logic                         busy;

   modport master (
      output in_valid, multiplicand, multiplier, acc_clear, out_ready,
      input  in_ready, out_valid, product, acc_out, busy
   );

   modport slave (
      input  in_valid, multiplicand, multiplier, acc_clear, out_ready,
      output in_ready, out_valid, product, acc_out, busy
   );
endinterface

// File: rtl/booth_pp_accumulator.sv
// Sequential radix-4 Booth multiplier with a wrapping signed accumulator.
// Define BOOTH_PP_EARLY_TERM_EN to finish as soon as the remaining multiplier groups are all zero.
//
//   state | meaning
//   IDLE  | waiting for an operand pair (in_ready=1)
//   RUN   | one Booth group added per cycle (busy=1)
//   DONE  | product held on out_valid until out_ready
module booth_pp_accumulator #(
   parameter int N_BITS   = 16,
   parameter int ACC_BITS = 40
) (
   input  logic                   clk,
   input  logic                   rst,
   booth_pp_accumulator_if.slave  bus
);
   localparam int P_BITS = 2 * N_BITS;
   localparam int GROUPS = N_BITS / 2;
   localparam int G_BITS = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam logic [G_BITS-1:0] LAST_GRP = G_BITS'(GROUPS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                    state;
   state_t                    state_nx;
   logic signed [N_BITS-1:0]  m_reg;
   logic signed [N_BITS-1:0]  q_reg;
   logic signed [P_BITS-1:0]  psum;
   logic signed [P_BITS-1:0]  product_reg;
   logic signed [ACC_BITS-1:0] acc_reg;
   logic [G_BITS-1:0]         grp;

   logic [N_BITS:0]           q_sh;
   logic [2:0]                triple;
   logic signed [P_BITS-1:0]  m_ext;
   logic signed [P_BITS-1:0]  digit;
   logic signed [P_BITS-1:0]  sum_nx;
   logic                      rest_uniform;
   logic                      last_grp;

   // Appending a zero below Q makes prev=0 for group 0 fall out of the same slice.
   always_comb begin
      q_sh   = {q_reg, 1'b0} >> {grp, 1'b0};
      triple = q_sh[2:0];
      m_ext  = {{N_BITS{m_reg[N_BITS-1]}}, m_reg};
      digit  = '0;
      unique case (triple)
         3'b001, 3'b010: digit = m_ext;
         3'b011:         digit = m_ext <<< 1;
         3'b100:         digit = -(m_ext <<< 1);
         3'b101, 3'b110: digit = -m_ext;
         default:        digit = '0;
      endcase
      sum_nx = psum + (digit << {grp, 1'b0});
   end

`ifdef BOOTH_PP_EARLY_TERM_EN
   logic signed [N_BITS-1:0] q_rest;

   // Bits above the current group all equal -> every remaining triple is 000 or 111.
   always_comb begin
      q_rest       = q_reg >>> ({1'b0, grp, 1'b0} + (G_BITS + 2)'(1));
      rest_uniform = (q_rest == '0) || (q_rest == '1);
   end
`else
   assign rest_uniform = 1'b0;
`endif

   assign last_grp = (grp == LAST_GRP) || rest_uniform;

   always_comb begin
      state_nx      = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      unique case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nx = RUN;
         end
         RUN: begin
            bus.busy = 1'b1;
            if (last_grp) state_nx = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         m_reg       <= '0;
         q_reg       <= '0;
         psum        <= '0;
         grp         <= '0;
         product_reg <= '0;
         acc_reg     <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && bus.in_valid) begin
            m_reg <= bus.multiplicand;
            q_reg <= bus.multiplier;
            psum  <= '0;
            grp   <= '0;
         end
         if (state == RUN) begin
            psum <= sum_nx;
            grp  <= grp + 1'b1;
            if (last_grp) product_reg <= sum_nx;
         end
         if (state == DONE && bus.out_ready) begin
            acc_reg <= (bus.acc_clear ? '0 : acc_reg) + ACC_BITS'(product_reg);
         end
      end
   end

   assign bus.product = product_reg;
   assign bus.acc_out = acc_reg;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Directed bench for booth_pp_accumulator: vector table plus backpressure and mid-run reset sequences.
module tb_booth_pp_accumulator;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cur_vec = -1;

   always #5 clk = ~clk;

   booth_pp_accumulator_if #(.N_BITS(16), .ACC_BITS(40)) bus ();

   booth_pp_accumulator #(.N_BITS(16), .ACC_BITS(40)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct packed {
      logic [15:0] m;
      logic [15:0] q;
      logic        clr;
      logic [31:0] p;
      logic [39:0] a;
      int          lat_et;
   } vec_t;

   vec_t vecs [13];

   function automatic int exp_lat(input int lat_et);
`ifdef BOOTH_PP_EARLY_TERM_EN
      return lat_et;
`else
      return 9;
`endif
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h", cur_vec, name, act, exp);
      end
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!bus.out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic do_op(input logic [15:0] m, input logic [15:0] q, input logic clr,
                        input logic [31:0] ep, input logic [39:0] ea, input int elat);
      int lat;
      @(negedge clk);
      check("in_ready_idle", 64'(bus.in_ready), 64'd1);
      bus.in_valid     = 1'b1;
      bus.multiplicand = m;
      bus.multiplier   = q;
      bus.acc_clear    = clr;
      bus.out_ready    = 1'b1;
      @(negedge clk);
      bus.in_valid     = 1'b0;
      bus.multiplicand = ~m;
      bus.multiplier   = q ^ 16'h5a5a;
      check("busy_run", 64'(bus.busy), 64'd1);
      wait_valid(lat);
      check("latency", 64'(lat), 64'(elat));
      check("product", 64'($unsigned(bus.product)), 64'(ep));
      check("in_ready_done", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      check("acc_out", 64'($unsigned(bus.acc_out)), 64'(ea));
      check("out_valid_after", 64'(bus.out_valid), 64'd0);
      bus.acc_clear = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      vecs[0]  = '{16'd3,     16'd5,     1'b1, 32'h0000000F, 40'h000000000F, 3};
      vecs[1]  = '{16'h8000,  16'h8000,  1'b1, 32'h40000000, 40'h0040000000, 9};
      vecs[2]  = '{16'd12345, 16'hFFFF,  1'b0, 32'hFFFFCFC7, 40'h003FFFCFC7, 2};
      vecs[3]  = '{16'd100,   16'd200,   1'b1, 32'h00004E20, 40'h0000004E20, 6};
      vecs[4]  = '{16'd300,   16'hFFFE,  1'b0, 32'hFFFFFDA8, 40'h0000004BC8, 2};
      vecs[5]  = '{16'd7,     16'd7,     1'b1, 32'h00000031, 40'h0000000031, 3};
      vecs[6]  = '{16'd0,     16'd1234,  1'b1, 32'h00000000, 40'h0000000000, 7};
      vecs[7]  = '{16'hFFFB,  16'd0,     1'b0, 32'h00000000, 40'h0000000000, 2};
      vecs[8]  = '{16'h8000,  16'd1,     1'b0, 32'hFFFF8000, 40'hFFFFFF8000, 2};
      vecs[9]  = '{16'h7FFF,  16'h8000,  1'b1, 32'hC0008000, 40'hFFC0008000, 9};
      vecs[10] = '{16'hFFF9,  16'hFFFD,  1'b0, 32'h00000015, 40'hFFC0008015, 3};
      vecs[11] = '{16'd9,     16'd1,     1'b1, 32'h00000009, 40'h0000000009, 2};
      vecs[12] = '{16'd9,     16'hFFFF,  1'b0, 32'hFFFFFFF7, 40'h0000000000, 2};

      bus.in_valid     = 1'b0;
      bus.multiplicand = '0;
      bus.multiplier   = '0;
      bus.acc_clear    = 1'b0;
      bus.out_ready    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_product", 64'($unsigned(bus.product)), 64'd0);
      check("rst_acc", 64'($unsigned(bus.acc_out)), 64'd0);

      for (int i = 0; i < 13; i++) begin
         cur_vec = i;
         do_op(vecs[i].m, vecs[i].q, vecs[i].clr, vecs[i].p, vecs[i].a, exp_lat(vecs[i].lat_et));
      end

      // Backpressure: result held in DONE, input pulses ignored, single accumulate on release.
      cur_vec = 100;
      @(negedge clk);
      bus.in_valid     = 1'b1;
      bus.multiplicand = 16'd11;
      bus.multiplier   = 16'd13;
      bus.acc_clear    = 1'b1;
      bus.out_ready    = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_valid(lat);
      check("bp_latency", 64'(lat), 64'(exp_lat(4)));
      for (int k = 0; k < 5; k++) begin
         check("bp_out_valid", 64'(bus.out_valid), 64'd1);
         check("bp_product", 64'($unsigned(bus.product)), 64'd143);
         check("bp_in_ready", 64'(bus.in_ready), 64'd0);
         bus.in_valid     = ~bus.in_valid;
         bus.multiplicand = 16'(k + 100);
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("bp_out_valid_rel", 64'(bus.out_valid), 64'd0);
      check("bp_in_ready_rel", 64'(bus.in_ready), 64'd1);
      check("bp_acc", 64'($unsigned(bus.acc_out)), 64'd143);
      bus.acc_clear = 1'b0;
      repeat (2) @(negedge clk);
      check("bp_acc_once", 64'($unsigned(bus.acc_out)), 64'd143);
      check("bp_idle", 64'(bus.out_valid), 64'd0);

      // Reset in the middle of RUN discards the result and zeroes the accumulator.
      cur_vec = 101;
      @(negedge clk);
      bus.in_valid     = 1'b1;
      bus.multiplicand = 16'd5;
      bus.multiplier   = 16'h4000;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_busy", 64'(bus.busy), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_out_valid", 64'(bus.out_valid), 64'd0);
      check("mid_in_ready", 64'(bus.in_ready), 64'd1);
      check("mid_busy_off", 64'(bus.busy), 64'd0);
      check("mid_acc", 64'($unsigned(bus.acc_out)), 64'd0);
      check("mid_product", 64'($unsigned(bus.product)), 64'd0);
      cur_vec = 102;
      do_op(16'd2, 16'd3, 1'b0, 32'd6, 40'd6, exp_lat(3));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
